// File: rtl/frame_bram_ctrl_pkg.sv
// Shared definitions for the frame capture controller.
// Holds the state codes, the default frame geometry and the RGB888 -> RGB332 packing.
package frame_bram_ctrl_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 400;
    localparam int ADDR_W_DEF   = 18;

    // These codes appear directly on the bram_state port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_WRITING = 2'b10,
        ST_READING = 2'b11
    } bram_state_e;

    function automatic logic [7:0] rgb332(input logic [23:0] px);
        return {px[23:21], px[15:13], px[7:6]};
    endfunction

endpackage

// File: rtl/frame_bram_ctrl_if.sv
// Bundle of the video, BRAM and PC-link signals around the frame controller.
// The controller uses the slave view; the surrounding system uses the master view.
interface frame_bram_ctrl_if
    import frame_bram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              store_bram;
    logic              send_pc;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [23:0]       pixel_in;
    logic [7:0]        bram_dout;
    logic              pc_req;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [7:0]        bram_din;
    logic [1:0]        bram_state;
    logic              in_display;
    logic [7:0]        pc_data;
    logic              pc_valid;
    logic              pc_done;

    modport master (
        output store_bram, send_pc, hcount, vcount, pixel_in, bram_dout, pc_req,
        input  bram_addr, bram_we, bram_din, bram_state, in_display,
               pc_data, pc_valid, pc_done
    );

    modport slave (
        input  store_bram, send_pc, hcount, vcount, pixel_in, bram_dout, pc_req,
        output bram_addr, bram_we, bram_din, bram_state, in_display,
               pc_data, pc_valid, pc_done
    );
endinterface

// File: rtl/frame_bram_ctrl_pc_byte_reader.sv
// PC readout handshake: an accepted request returns the byte at the PC pointer two
// cycles later and advances the pointer; done is flagged once every pixel has gone out.
module pc_byte_reader
    import frame_bram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TOTAL  = H_ACTIVE_DEF * V_ACTIVE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              send_pc_i,
    input  logic              pc_req_i,
    input  logic [7:0]        bram_dout_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        pc_data_o,
    output logic              pc_valid_o,
    output logic              pc_done_o
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL);

    logic             pending_q;
    logic             valid_q;
    logic             done_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] ptr_q;
    logic [CNT_W-1:0] ptr_d;

    assign ptr_d = ptr_q + 1'b1;

    // Pointer steps together with valid so the next address is already on the BRAM
    // by the time a request spaced three or more cycles later samples the read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
            ptr_q     <= '0;
        end else if (!send_pc_i) begin
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (pending_q) begin
                pending_q <= 1'b0;
                valid_q   <= 1'b1;
                data_q    <= bram_dout_i;
                ptr_q     <= ptr_d;
            end else if (enable_i && pc_req_i && !valid_q && !done_q) begin
                pending_q <= 1'b1;
            end
            if (valid_q && ptr_q == LAST) begin
                done_q <= 1'b1;
            end
        end
    end

    assign addr_o     = ptr_q[ADDR_W-1:0];
    assign pc_data_o  = data_q;
    assign pc_valid_o = valid_q;
    assign pc_done_o  = done_q;

endmodule

// File: rtl/frame_bram_ctrl.sv
// Frame capture controller: grabs one RGB332 frame into BRAM on request, then
// serves it to the display scanout or byte-by-byte to the PC sender.
module frame_bram_ctrl
    import frame_bram_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input logic              clk,
    input logic              reset_n,
    frame_bram_ctrl_if.slave bus
);
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL);

    logic              active;
    logic              frameStart;
    logic              storeRise;
    logic              abort;
    logic              sendMode;
    logic [CNT_W-1:0]  dispBase;
    logic [CNT_W-1:0]  dispCnt_d;
    logic [ADDR_W-1:0] pcAddr;
    logic [7:0]        pcData;
    logic              pcValid;
    logic              pcDone;

    bram_state_e       state_q;
    logic              storePrev_q;
    logic [CNT_W-1:0]  writeCnt_q;
    logic [CNT_W-1:0]  dispCnt_q;
    logic [ADDR_W-1:0] bramAddr_q;
    logic              bramWe_q;
    logic [7:0]        bramDin_q;
    logic              inDisplay_q;

    assign active     = (int'(bus.hcount) < H_ACTIVE) && (int'(bus.vcount) < V_ACTIVE);
    assign frameStart = (bus.hcount == '0) && (bus.vcount == '0);
    assign storeRise  = bus.store_bram && !storePrev_q;
    assign abort      = !bus.store_bram && !bus.send_pc;
    assign sendMode   = (state_q == ST_READING) && bus.send_pc;
    assign dispBase   = frameStart ? '0 : dispCnt_q;
    assign dispCnt_d  = active ? dispBase + 1'b1 : dispBase;

    // storePrev_q comes out of reset high so a store_bram still held across a
    // reset does not look like a fresh request and restart the capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            storePrev_q <= 1'b1;
            writeCnt_q  <= '0;
            dispCnt_q   <= '0;
            bramAddr_q  <= '0;
            bramWe_q    <= 1'b0;
            bramDin_q   <= '0;
            inDisplay_q <= 1'b0;
        end else begin
            storePrev_q <= bus.store_bram;
            dispCnt_q   <= dispCnt_d;
            bramWe_q    <= 1'b0;
            inDisplay_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (storeRise) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (frameStart) begin
                        state_q    <= ST_WRITING;
                        bramWe_q   <= 1'b1;
                        bramAddr_q <= '0;
                        bramDin_q  <= rgb332(bus.pixel_in);
                        writeCnt_q <= CNT_W'(1);
                    end
                end
                ST_WRITING: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (writeCnt_q == LAST) begin
                        state_q <= ST_READING;
                    end else if (active) begin
                        bramWe_q   <= 1'b1;
                        bramAddr_q <= writeCnt_q[ADDR_W-1:0];
                        bramDin_q  <= rgb332(bus.pixel_in);
                        writeCnt_q <= writeCnt_q + 1'b1;
                    end
                end
                ST_READING: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (sendMode) begin
                        bramAddr_q <= pcAddr;
                    end else begin
                        bramAddr_q  <= dispBase[ADDR_W-1:0];
                        inDisplay_q <= active;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pc_byte_reader #(
        .ADDR_W(ADDR_W),
        .TOTAL (TOTAL)
    ) u_pc_byte_reader (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable_i   (sendMode),
        .send_pc_i  (bus.send_pc),
        .pc_req_i   (bus.pc_req),
        .bram_dout_i(bus.bram_dout),
        .addr_o     (pcAddr),
        .pc_data_o  (pcData),
        .pc_valid_o (pcValid),
        .pc_done_o  (pcDone)
    );

    assign bus.bram_addr  = bramAddr_q;
    assign bus.bram_we    = bramWe_q;
    assign bus.bram_din   = bramDin_q;
    assign bus.bram_state = state_q;
    assign bus.in_display = inDisplay_q;
    assign bus.pc_data    = pcData;
    assign bus.pc_valid   = pcValid;
    assign bus.pc_done    = pcDone;

endmodule

// File: tb/tb_frame_bram_ctrl.sv
// Self-checking bench for frame_bram_ctrl on a reduced 16x8 frame with a small
// BRAM model; expectations come from pixel coordinates and a reference image.
module tb_frame_bram_ctrl;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int AW    = 7;
    localparam int TOTAL = H * V;
    localparam int H_TOT = 20;
    localparam int V_TOT = 10;
    localparam int FRAME = H_TOT * V_TOT;

    logic clk = 1'b0;
    logic reset_n;
    int   compared   = 0;
    int   mismatched = 0;

    logic [23:0] img [TOTAL];
    logic [7:0]  mem [TOTAL];

    frame_bram_ctrl_if #(.ADDR_W(AW)) bus ();

    frame_bram_ctrl #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // BRAM model: synchronous write, registered read data one cycle after the address.
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr];
    end

    // Reference image plus a free-running VGA raster, advanced on the falling edge.
    initial begin
        int hc;
        int vc;
        for (int i = 0; i < TOTAL; i++) img[i] = 24'($urandom);
        img[5] = 24'hFFC080;
        hc = 0;
        vc = 0;
        bus.hcount   = '0;
        bus.vcount   = '0;
        bus.pixel_in = img[0];
        forever begin
            @(negedge clk);
            if (hc == H_TOT - 1) begin
                hc = 0;
                vc = (vc == V_TOT - 1) ? 0 : vc + 1;
            end else begin
                hc = hc + 1;
            end
            bus.hcount   = 11'(hc);
            bus.vcount   = 10'(vc);
            bus.pixel_in = (hc < H && vc < V) ? img[vc * H + hc] : 24'h0;
        end
    end

    function automatic logic [7:0] ref332(input logic [23:0] px);
        int r;
        int g;
        int b;
        r = int'(px[23:16]);
        g = int'(px[15:8]);
        b = int'(px[7:0]);
        return 8'((r / 32) * 32 + (g / 32) * 4 + b / 64);
    endfunction

    function automatic bit isActive();
        return int'(bus.hcount) < H && int'(bus.vcount) < V;
    endfunction

    function automatic int pixAddr();
        return int'(bus.vcount) * H + int'(bus.hcount);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitLine(input int line, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME && !ok; c++) begin
            cycle();
            if (int'(bus.vcount) == line && int'(bus.hcount) == 2) ok = 1'b1;
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_line: got no line %0d required line %0d", line, line);
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.store_bram = 1'b0;
        bus.send_pc    = 1'b0;
        bus.pc_req     = 1'b0;
        cycle();
        cycle();
        compared++;
        if (bus.bram_state !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %0b required 00", bus.bram_state);
        end
        compared++;
        if (bus.bram_we !== 1'b0 || bus.bram_addr !== '0 || bus.bram_din !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_bram: got we=%0b addr=%0h din=%0h required 0/0/0",
                     bus.bram_we, bus.bram_addr, bus.bram_din);
        end
        compared++;
        if (bus.in_display !== 1'b0 || bus.pc_valid !== 1'b0 || bus.pc_done !== 1'b0 ||
            bus.pc_data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_pc: got disp=%0b valid=%0b done=%0b data=%0h required all 0",
                     bus.in_display, bus.pc_valid, bus.pc_done, bus.pc_data);
        end
        reset_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_capture();
        bit ok;
        bit started;
        bit done;
        bit expWe;
        int writes;
        int seenWe;
        int seenFive;
        logic [1:0] expState;
        started  = 1'b0;
        done     = 1'b0;
        writes   = 0;
        seenWe   = 0;
        seenFive = 0;
        waitLine(3, ok);
        bus.store_bram = 1'b1;
        for (int c = 0; c < 3 * FRAME && !done; c++) begin
            cycle();
            if (!started && bus.hcount == 0 && bus.vcount == 0) started = 1'b1;
            expWe = started && writes < TOTAL && isActive();
            if (!started) expState = 2'b01;
            else if (writes < TOTAL) expState = 2'b10;
            else begin
                expState = 2'b11;
                done = 1'b1;
            end
            if (bus.bram_we === 1'b1) seenWe++;
            compared++;
            if (bus.bram_we !== expWe) begin
                mismatched++;
                $display("[TB] FAIL cap_we (%0d,%0d): got %0b required %0b",
                         bus.hcount, bus.vcount, bus.bram_we, expWe);
            end
            compared++;
            if (bus.bram_state !== expState) begin
                mismatched++;
                $display("[TB] FAIL cap_state (%0d,%0d): got %0b required %0b",
                         bus.hcount, bus.vcount, bus.bram_state, expState);
            end
            if (expWe) begin
                compared++;
                if (int'(bus.bram_addr) != pixAddr() ||
                    bus.bram_din !== ref332(img[pixAddr()])) begin
                    mismatched++;
                    $display("[TB] FAIL cap_data (%0d,%0d): got addr=%0d din=%0h required addr=%0d din=%0h",
                             bus.hcount, bus.vcount, bus.bram_addr, bus.bram_din,
                             pixAddr(), ref332(img[pixAddr()]));
                end
                writes++;
            end
            if (bus.bram_we === 1'b1 && bus.bram_addr == 5) begin
                seenFive++;
                compared++;
                if (bus.bram_din !== 8'hFA) begin
                    mismatched++;
                    $display("[TB] FAIL cap_addr5: got %0h required fa", bus.bram_din);
                end
            end
        end
        compared++;
        if (!done || seenWe != TOTAL || seenFive != 1) begin
            mismatched++;
            $display("[TB] FAIL cap_total: got done=%0b writes=%0d addr5=%0d required 1/%0d/1",
                     done, seenWe, seenFive, TOTAL);
        end
    endtask

    task automatic test_display();
        bit found;
        bit seen31;
        found  = 1'b0;
        seen31 = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            cycle();
            if (bus.hcount == 0 && bus.vcount == 0) found = 1'b1;
        end
        for (int c = 0; c < FRAME && found; c++) begin
            if (c > 0) cycle();
            compared++;
            if (bus.in_display !== isActive() || bus.bram_we !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL disp_flags (%0d,%0d): got disp=%0b we=%0b required %0b/0",
                         bus.hcount, bus.vcount, bus.in_display, bus.bram_we, isActive());
            end
            if (isActive()) begin
                compared++;
                if (int'(bus.bram_addr) != pixAddr()) begin
                    mismatched++;
                    $display("[TB] FAIL disp_addr (%0d,%0d): got %0d required %0d",
                             bus.hcount, bus.vcount, bus.bram_addr, pixAddr());
                end
            end
            if (bus.hcount == 3 && bus.vcount == 1) begin
                seen31 = 1'b1;
                compared++;
                if (int'(bus.bram_addr) != H + 3 || bus.in_display !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL disp_3_1: got addr=%0d disp=%0b required %0d/1",
                             bus.bram_addr, bus.in_display, H + 3);
                end
            end
        end
        compared++;
        if (!found || !seen31) begin
            mismatched++;
            $display("[TB] FAIL disp_reached: got start=%0b pix31=%0b required 1/1", found, seen31);
        end
    endtask

    task automatic test_pc_transfer();
        int gap;
        bus.send_pc = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < TOTAL; i++) begin
            bus.pc_req = 1'b1;
            cycle();
            bus.pc_req = 1'b0;
            compared++;
            if (bus.pc_valid !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pc_early byte %0d: got valid=%0b required 0", i, bus.pc_valid);
            end
            cycle();
            compared++;
            if (bus.pc_valid !== 1'b1 || bus.pc_data !== ref332(img[i]) ||
                bus.pc_done !== 1'b0 || bus.in_display !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL pc_byte %0d: got valid=%0b data=%0h done=%0b disp=%0b required 1/%0h/0/0",
                         i, bus.pc_valid, bus.pc_data, bus.pc_done, bus.in_display, ref332(img[i]));
            end
            gap = $urandom_range(1, 4);
            repeat (gap) begin
                cycle();
                compared++;
                if (bus.pc_valid !== 1'b0 || bus.pc_done !== (i == TOTAL - 1)) begin
                    mismatched++;
                    $display("[TB] FAIL pc_gap byte %0d: got valid=%0b done=%0b required 0/%0b",
                             i, bus.pc_valid, bus.pc_done, (i == TOTAL - 1));
                end
            end
        end
        bus.pc_req = 1'b1;
        cycle();
        bus.pc_req = 1'b0;
        repeat (3) begin
            cycle();
            compared++;
            if (bus.pc_valid !== 1'b0 || bus.pc_done !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL pc_after_done: got valid=%0b done=%0b required 0/1",
                         bus.pc_valid, bus.pc_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [7:0] data;
        pulses = 0;
        data   = '0;
        bus.send_pc = 1'b0;
        cycle();
        compared++;
        if (bus.pc_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL pc_done_clear: got %0b required 0", bus.pc_done);
        end
        bus.send_pc = 1'b1;
        repeat (3) cycle();
        bus.pc_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k == 1) bus.pc_req = 1'b0;
            if (bus.pc_valid === 1'b1) begin
                pulses++;
                data = bus.pc_data;
            end
        end
        compared++;
        if (pulses != 1 || data !== ref332(img[0])) begin
            mismatched++;
            $display("[TB] FAIL b2b: got pulses=%0d data=%0h required 1/%0h",
                     pulses, data, ref332(img[0]));
        end
        bus.store_bram = 1'b0;
        repeat (3) begin
            cycle();
            compared++;
            if (bus.bram_state !== 2'b11) begin
                mismatched++;
                $display("[TB] FAIL store_hold: got %0b required 11", bus.bram_state);
            end
        end
        bus.send_pc = 1'b0;
        cycle();
        compared++;
        if (bus.bram_state !== 2'b00 || bus.bram_we !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL store_release: got state=%0b we=%0b required 00/0",
                     bus.bram_state, bus.bram_we);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit hit;
        int k;
        hit = 1'b0;
        k   = $urandom_range(20, TOTAL - 20);
        waitLine(3, ok);
        bus.store_bram = 1'b1;
        for (int c = 0; c < 3 * FRAME && !hit; c++) begin
            cycle();
            if (bus.bram_we === 1'b1 && int'(bus.bram_addr) == k) hit = 1'b1;
        end
        bus.store_bram = 1'b0;
        cycle();
        compared++;
        if (!hit || bus.bram_we !== 1'b0 || bus.bram_state !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL abort at %0d: got hit=%0b we=%0b state=%0b required 1/0/00",
                     k, hit, bus.bram_we, bus.bram_state);
        end
        repeat (2) cycle();
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        bit hit;
        int k;
        int lateWrites;
        int badState;
        hit        = 1'b0;
        lateWrites = 0;
        badState   = 0;
        k          = $urandom_range(10, TOTAL - 10);
        waitLine(3, ok);
        bus.store_bram = 1'b1;
        for (int c = 0; c < 3 * FRAME && !hit; c++) begin
            cycle();
            if (bus.bram_we === 1'b1 && int'(bus.bram_addr) == k) hit = 1'b1;
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if (!hit || bus.bram_state !== 2'b00 || bus.bram_we !== 1'b0 || bus.bram_addr !== '0 ||
            bus.bram_din !== 8'h00 || bus.in_display !== 1'b0 || bus.pc_data !== 8'h00 ||
            bus.pc_valid !== 1'b0 || bus.pc_done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got hit=%0b state=%0b we=%0b addr=%0h din=%0h pc_data=%0h required 1/00/0/0/0/0",
                     hit, bus.bram_state, bus.bram_we, bus.bram_addr, bus.bram_din, bus.pc_data);
        end
        cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            cycle();
            if (bus.bram_we !== 1'b0) lateWrites++;
            if (bus.bram_state !== 2'b00) badState++;
        end
        compared++;
        if (lateWrites != 0 || badState != 0) begin
            mismatched++;
            $display("[TB] FAIL post_reset: got writes=%0d nonidle=%0d required 0/0",
                     lateWrites, badState);
        end
    endtask

    initial begin
        $display("[TB] frame_bram_ctrl bench start, %0dx%0d frame", H, V);
        test_reset();
        test_capture();
        test_display();
        test_pc_transfer();
        test_back_to_back();
        test_abort();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
